// File: rtl/iecdrv_cia_bus_seq.sv
`default_nettype none
// ============================================================================
// Module   : iecdrv_cia_bus_seq
// Brief    : phi2 strobe generator and one-access-per-slot CIA bus sequencer
//            shared by the drive CPU (priority) and a host read/write/poll port.
// Revision : 1.0 - initial release
// ============================================================================
module iecdrv_cia_bus_seq #(
    parameter int DIV      = 16,
    parameter int POLL_MAX = 255
) (
    input  logic       clk,
    input  logic       reset,
    output logic       phi2_p,
    output logic       phi2_n,
    output logic       cia_cs_n,
    output logic       cia_rw,
    output logic [3:0] cia_rs,
    output logic [7:0] cia_din,
    input  logic [7:0] cia_dout,
    input  logic       cpu_req,
    input  logic       cpu_rw,
    input  logic [3:0] cpu_rs,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    output logic       cpu_done,
    input  logic       host_req,
    input  logic [1:0] host_op,
    input  logic [3:0] host_rs,
    input  logic [7:0] host_wdata,
    input  logic [7:0] host_mask,
    input  logic [7:0] host_match,
    output logic       host_ack,
    output logic [7:0] host_rdata,
    output logic       host_timeout,
    output logic [1:0] bus_owner
);

    localparam int              CW          = (DIV <= 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0]   CNT_LAST    = CW'(DIV - 1);
    localparam logic [CW-1:0]   CNT_HALF    = CW'(DIV / 2);
    localparam logic [CW-1:0]   CNT_HALF_M1 = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0]   CNT_CAP     = CW'(DIV / 2 + 1);
    localparam logic [7:0]      PMAX        = 8'(POLL_MAX);

    localparam logic [1:0] OWN_IDLE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_HOST = 2'd2;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_POLL  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_EVAL   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phi2_p_q, phi2_p_d, phi2_n_q, phi2_n_d;
    logic          cs_n_q, cs_n_d, rw_q, rw_d;
    logic [3:0]    rs_q, rs_d;
    logic [7:0]    din_q, din_d;
    logic [1:0]    owner_q, owner_d;
    logic [7:0]    cpu_rdata_q, cpu_rdata_d;
    logic [1:0]    h_op_q, h_op_d;
    logic [3:0]    h_rs_q, h_rs_d;
    logic [7:0]    h_wdata_q, h_wdata_d, h_mask_q, h_mask_d, h_match_q, h_match_d;
    logic [7:0]    pcnt_q, pcnt_d;
    logic [7:0]    host_rdata_q, host_rdata_d;
    logic          host_tmo_q, host_tmo_d;
    logic          eval_ack, eval_tmo, poll_hit, cap_cycle;

    assign cap_cycle = (cnt_q == CNT_CAP);
    assign poll_hit  = (((cia_dout ^ h_match_q) & h_mask_q) == 8'h00);

    always_comb begin
        cnt_d        = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        phi2_p_d     = (cnt_q == CNT_LAST);
        phi2_n_d     = (cnt_q == CNT_HALF_M1);
        cs_n_d       = cs_n_q;
        rw_d         = rw_q;
        rs_d         = rs_q;
        din_d        = din_q;
        owner_d      = owner_q;
        cpu_rdata_d  = cpu_rdata_q;
        state_d      = state_q;
        h_op_d       = h_op_q;
        h_rs_d       = h_rs_q;
        h_wdata_d    = h_wdata_q;
        h_mask_d     = h_mask_q;
        h_match_d    = h_match_q;
        pcnt_d       = pcnt_q;
        host_rdata_d = host_rdata_q;
        host_tmo_d   = host_tmo_q;
        eval_ack     = 1'b0;
        eval_tmo     = 1'b0;

        // Slot arbitration: the CPU always wins; its request is only looked at here.
        if (cnt_q == '0) begin
            if (cpu_req) begin
                owner_d = OWN_CPU;
                cs_n_d  = 1'b0;
                rw_d    = cpu_rw;
                rs_d    = cpu_rs;
                din_d   = cpu_wdata;
            end else if (state_q == ST_ACCESS) begin
                owner_d = OWN_HOST;
                cs_n_d  = 1'b0;
                rw_d    = (h_op_q != OP_WRITE);
                rs_d    = h_rs_q;
                din_d   = h_wdata_q;
            end else begin
                owner_d = OWN_IDLE;
                cs_n_d  = 1'b1;
                rw_d    = 1'b1;
            end
        end else if (cnt_q == CNT_LAST) begin
            owner_d = OWN_IDLE;
            cs_n_d  = 1'b1;
            rw_d    = 1'b1;
        end

        if (cap_cycle && (owner_q == OWN_CPU) && rw_q) begin
            cpu_rdata_d = cia_dout;
        end

        case (state_q)
            ST_IDLE: begin
                if (host_req) begin
                    h_op_d    = host_op;
                    h_rs_d    = host_rs;
                    h_wdata_d = host_wdata;
                    h_mask_d  = host_mask;
                    h_match_d = host_match;
                    pcnt_d    = 8'h00;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Moving one cycle early puts EVAL exactly on the capture cycle.
                if ((cnt_q == CNT_HALF) && (owner_q == OWN_HOST)) begin
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (h_op_q != OP_POLL) begin
                    eval_ack = 1'b1;
                end else if (poll_hit) begin
                    eval_ack = 1'b1;
                end else begin
                    pcnt_d = pcnt_q + 8'd1;
                    if (pcnt_d == PMAX) begin
                        eval_ack = 1'b1;
                        eval_tmo = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
                if (eval_ack) begin
                    state_d    = ST_DONE;
                    host_tmo_d = eval_tmo;
                    if (h_op_q != OP_WRITE) begin
                        host_rdata_d = cia_dout;
                    end
                end
            end
            ST_DONE: begin
                if (!host_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            phi2_p_q     <= 1'b0;
            phi2_n_q     <= 1'b0;
            cs_n_q       <= 1'b1;
            rw_q         <= 1'b1;
            rs_q         <= 4'h0;
            din_q        <= 8'h00;
            owner_q      <= OWN_IDLE;
            cpu_rdata_q  <= 8'h00;
            h_op_q       <= 2'd0;
            h_rs_q       <= 4'h0;
            h_wdata_q    <= 8'h00;
            h_mask_q     <= 8'h00;
            h_match_q    <= 8'h00;
            pcnt_q       <= 8'h00;
            host_rdata_q <= 8'h00;
            host_tmo_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            phi2_p_q     <= phi2_p_d;
            phi2_n_q     <= phi2_n_d;
            cs_n_q       <= cs_n_d;
            rw_q         <= rw_d;
            rs_q         <= rs_d;
            din_q        <= din_d;
            owner_q      <= owner_d;
            cpu_rdata_q  <= cpu_rdata_d;
            h_op_q       <= h_op_d;
            h_rs_q       <= h_rs_d;
            h_wdata_q    <= h_wdata_d;
            h_mask_q     <= h_mask_d;
            h_match_q    <= h_match_d;
            pcnt_q       <= pcnt_d;
            host_rdata_q <= host_rdata_d;
            host_tmo_q   <= host_tmo_d;
        end
    end

    // Completion results are forwarded combinationally so they are valid with the pulse.
    assign phi2_p       = phi2_p_q;
    assign phi2_n       = phi2_n_q;
    assign cia_cs_n     = cs_n_q;
    assign cia_rw       = rw_q;
    assign cia_rs       = rs_q;
    assign cia_din      = din_q;
    assign bus_owner    = owner_q;
    assign cpu_done     = cap_cycle && (owner_q == OWN_CPU);
    assign cpu_rdata    = cpu_rdata_d;
    assign host_ack     = eval_ack;
    assign host_rdata   = host_rdata_d;
    assign host_timeout = host_tmo_d;

endmodule
`default_nettype wire

// File: tb/tb_iecdrv_cia_bus_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_iecdrv_cia_bus_seq
// Brief    : slot-level scoreboard bench for the CIA bus sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iecdrv_cia_bus_seq;

    localparam int DIV      = 16;
    localparam int POLL_MAX = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic       phi2_p, phi2_n, cia_cs_n, cia_rw;
    logic [3:0] cia_rs;
    logic [7:0] cia_din, cia_dout;
    logic       cpu_req, cpu_rw;
    logic [3:0] cpu_rs;
    logic [7:0] cpu_wdata, cpu_rdata;
    logic       cpu_done;
    logic       host_req;
    logic [1:0] host_op;
    logic [3:0] host_rs;
    logic [7:0] host_wdata, host_mask, host_match, host_rdata;
    logic       host_ack, host_timeout;
    logic [1:0] bus_owner;

    always #5 clk = ~clk;

    iecdrv_cia_bus_seq #(.DIV(DIV), .POLL_MAX(POLL_MAX)) dut (
        .clk(clk), .reset(reset), .phi2_p(phi2_p), .phi2_n(phi2_n),
        .cia_cs_n(cia_cs_n), .cia_rw(cia_rw), .cia_rs(cia_rs), .cia_din(cia_din),
        .cia_dout(cia_dout), .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_rs(cpu_rs),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .host_req(host_req), .host_op(host_op), .host_rs(host_rs),
        .host_wdata(host_wdata), .host_mask(host_mask), .host_match(host_match),
        .host_ack(host_ack), .host_rdata(host_rdata), .host_timeout(host_timeout),
        .bus_owner(bus_owner)
    );

    typedef struct packed {
        logic [1:0] own;
        logic       rw;
        logic [3:0] rs;
        logic [7:0] din;
    } bus_t;

    bus_t       bus_q[$];
    logic [7:0] cpu_q[$];
    logic [8:0] host_q[$];
    bus_t       mb;
    logic [7:0] mc;
    logic [8:0] mh;

    int  n_chk  = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;
    int  ph     = -1000;

    // Reference host/CPU state at transaction level.
    int         h_state = 0;   // 0 none, 1 pending, 2 finished but request still held
    bit         h_hold;
    logic [1:0] m_op;
    logic [3:0] m_rs;
    logic [7:0] m_wd, m_mask, m_match;
    int         m_pc;
    logic [7:0] m_host_rd = 8'h00;
    logic [7:0] m_cpu_rd  = 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event without expectation or bound expired", name);
    endtask

    always @(negedge clk) begin
        if (phi2_p) ph = 0;
        else if (ph >= 0) ph++;
        if (mon_en) begin
            if (phi2_p) begin
                check("slot0_cs_n", cia_cs_n, 1);
                check("slot0_owner", bus_owner, 0);
            end
            if (ph == 5) begin
                if (bus_q.size() == 0) fail_now("bus_queue_empty");
                else begin
                    mb = bus_q.pop_front();
                    check("bus_owner", bus_owner, mb.own);
                    if (mb.own != 2'd0) begin
                        check("bus_cs_n", cia_cs_n, 0);
                        check("bus_rw", cia_rw, mb.rw);
                        check("bus_rs", cia_rs, mb.rs);
                        if (!mb.rw) check("bus_din", cia_din, mb.din);
                    end else begin
                        check("idle_cs_rw", {cia_cs_n, cia_rw}, 2'b11);
                    end
                end
            end
            if (cpu_done) begin
                check("cpu_done_phase", ph, DIV / 2 + 1);
                if (cpu_q.size() == 0) fail_now("cpu_done_unexpected");
                else begin
                    mc = cpu_q.pop_front();
                    check("cpu_rdata", cpu_rdata, mc);
                end
            end
            if (host_ack) begin
                check("host_ack_phase", ph, DIV / 2 + 1);
                if (host_q.size() == 0) fail_now("host_ack_unexpected");
                else begin
                    mh = host_q.pop_front();
                    check("host_result", {host_timeout, host_rdata}, mh);
                end
            end
        end
    end

    task automatic wait_slot();
        int n = 0;
        @(negedge clk);
        while (!phi2_p && n < 2 * DIV) begin
            @(negedge clk);
            n++;
        end
        if (!phi2_p) fail_now("phi2_p_wait");
    endtask

    // One phi2 slot: drive at count 0, optionally start a host op at count 3,
    // release the host request at count 10 once the model says it completed.
    task automatic run_slot(input bit creq, input bit crw, input logic [3:0] crs,
                            input logic [7:0] cwd, input logic [7:0] dout,
                            input bit hstart, input bit hold, input logic [1:0] hop,
                            input logic [3:0] hrs, input logic [7:0] hwd,
                            input logic [7:0] hmask, input logic [7:0] hmatch);
        bus_t b;
        bit   fin = 1'b0;
        bit   tmo = 1'b0;
        wait_slot();
        mon_en    = 1'b1;
        cpu_req   = creq;
        cpu_rw    = crw;
        cpu_rs    = crs;
        cpu_wdata = cwd;
        cia_dout  = dout;
        if (creq) begin
            b.own = 2'd1; b.rw = crw; b.rs = crs; b.din = cwd;
            cpu_q.push_back(crw ? dout : m_cpu_rd);
            if (crw) m_cpu_rd = dout;
        end else if (h_state == 1) begin
            b.own = 2'd2; b.rw = (m_op != 2'd1); b.rs = m_rs; b.din = m_wd;
            if (m_op == 2'd2) begin
                if (((dout ^ m_match) & m_mask) == 8'h00) fin = 1'b1;
                else begin
                    m_pc++;
                    if (m_pc == POLL_MAX) begin
                        fin = 1'b1;
                        tmo = 1'b1;
                    end
                end
            end else begin
                fin = 1'b1;
            end
            if (fin) begin
                if (m_op != 2'd1) m_host_rd = dout;
                host_q.push_back({tmo, m_host_rd});
            end
        end else begin
            b.own = 2'd0; b.rw = 1'b1; b.rs = 4'h0; b.din = 8'h00;
        end
        bus_q.push_back(b);

        repeat (3) @(negedge clk);
        cpu_req = 1'($urandom);
        if (h_state == 0 && hstart) begin
            host_req = 1'b1; host_op = hop; host_rs = hrs;
            host_wdata = hwd; host_mask = hmask; host_match = hmatch;
            m_op = hop; m_rs = hrs; m_wd = hwd; m_mask = hmask; m_match = hmatch;
            m_pc = 0; h_hold = hold; h_state = 1;
        end else if (h_state != 0) begin
            host_op = 2'($urandom); host_rs = 4'($urandom); host_wdata = 8'($urandom);
            host_mask = 8'($urandom); host_match = 8'($urandom);
        end

        repeat (7) @(negedge clk);
        if (h_state == 2) begin
            host_req = 1'b0;
            h_state  = 0;
        end else if (fin) begin
            if (h_hold) h_state = 2;
            else begin
                host_req = 1'b0;
                h_state  = 0;
            end
        end
    endtask

    task automatic idle_slot(input logic [7:0] dout);
        run_slot(1'b0, 1'b1, 4'h0, 8'h00, dout, 1'b0, 1'b0, 2'd0, 4'h0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic do_reset(input int cycles);
        int n       = 0;
        bit saw_ack = 1'b0;
        mon_en   = 1'b0;
        reset    = 1'b1;
        host_req = 1'b0;
        cpu_req  = 1'b0;
        repeat (cycles) @(negedge clk);
        check("reset_outputs",
              {phi2_p, phi2_n, cia_cs_n, cia_rw, cia_rs, cia_din, cpu_rdata, cpu_done,
               host_ack, host_rdata, host_timeout, bus_owner},
              {1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 2'd0});
        reset = 1'b0;
        bus_q.delete(); cpu_q.delete(); host_q.delete();
        h_state = 0; m_pc = 0; m_host_rd = 8'h00; m_cpu_rd = 8'h00;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (host_ack) saw_ack = 1'b1;
        end while (!phi2_p && n < 4 * DIV);
        check("phi2_p_after_reset", n, DIV);
        check("no_ack_after_reset", saw_ack, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] poll_seq [5];
        reset = 1'b1; cpu_req = 1'b0; cpu_rw = 1'b1; cpu_rs = 4'h0; cpu_wdata = 8'h00;
        cia_dout = 8'h00; host_req = 1'b0; host_op = 2'd0; host_rs = 4'h0;
        host_wdata = 8'h00; host_mask = 8'h00; host_match = 8'h00;
        do_reset(3);

        // CPU read of register 2
        run_slot(1'b1, 1'b1, 4'h2, 8'h00, 8'h5A, 1'b0, 1'b0, 2'd0, 4'h0, 8'h00, 8'h00, 8'h00);
        // Host write with request held past the ack
        run_slot(1'b0, 1'b1, 4'h0, 8'h00, 8'h00, 1'b1, 1'b1, 2'd1, 4'h4, 8'h34, 8'h00, 8'h00);
        idle_slot(8'hEE);
        idle_slot(8'hEE);
        idle_slot(8'hEE);
        // Host read starved by three CPU slots
        run_slot(1'b1, 1'b1, 4'h3, 8'h00, 8'h11, 1'b1, 1'b0, 2'd0, 4'h7, 8'h00, 8'h00, 8'h00);
        run_slot(1'b1, 1'b0, 4'h5, 8'hC3, 8'h22, 1'b0, 1'b0, 2'd0, 4'h0, 8'h00, 8'h00, 8'h00);
        run_slot(1'b1, 1'b1, 4'h6, 8'h00, 8'h33, 1'b0, 1'b0, 2'd0, 4'h0, 8'h00, 8'h00, 8'h00);
        idle_slot(8'h44);
        // Poll ICR bit 3: four misses then a hit
        run_slot(1'b0, 1'b1, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0, 2'd2, 4'hD, 8'h00, 8'h08, 8'h08);
        poll_seq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h88};
        foreach (poll_seq[i]) idle_slot(poll_seq[i]);
        // Poll that never matches runs out after POLL_MAX reads
        run_slot(1'b0, 1'b1, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0, 2'd2, 4'h1, 8'h00, 8'hFF, 8'h01);
        for (int i = 0; i < POLL_MAX + 1; i++) idle_slot(8'h00);
        // Reserved opcode behaves as a read
        run_slot(1'b0, 1'b1, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0, 2'd3, 4'h9, 8'h00, 8'h00, 8'h00);
        idle_slot(8'hA7);

        for (int s = 0; s < 160; s++) begin
            logic [7:0] msk;
            msk = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'(8'h01 << $urandom_range(0, 7));
            run_slot($urandom_range(0, 9) < 3, 1'($urandom), 4'($urandom), 8'($urandom),
                     8'($urandom), $urandom_range(0, 9) < 4, 1'($urandom),
                     2'($urandom), 4'($urandom), 8'($urandom), msk, 8'($urandom));
        end
        for (int s = 0; s < 40 && h_state != 0; s++) idle_slot(8'($urandom));
        idle_slot(8'h00);
        mon_en = 1'b0;
        check("queues_drained", {bus_q.size(), cpu_q.size(), host_q.size()}, 0);

        // Reset while a poll is waiting on its granted slot
        run_slot(1'b0, 1'b1, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0, 2'd2, 4'hD, 8'h00, 8'hFF, 8'h01);
        wait_slot();
        mon_en   = 1'b0;
        cpu_req  = 1'b0;
        cia_dout = 8'h00;
        repeat (5) @(negedge clk);
        check("mid_poll_owner", bus_owner, 2);
        do_reset(1);

        // Fresh host read proves the FSM came back idle
        run_slot(1'b0, 1'b1, 4'h0, 8'h00, 8'h00, 1'b1, 1'b0, 2'd0, 4'h2, 8'h00, 8'h00, 8'h00);
        idle_slot(8'h9C);
        idle_slot(8'h00);
        mon_en = 1'b0;
        check("queues_drained_end", {bus_q.size(), cpu_q.size(), host_q.size()}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iecdrv_cia_bus_seq.md
Name: iecdrv_cia_bus_seq

Overview:
- Generates the phi2 phase strobes for a drive-side 8520/6526 CIA instance.
- Drives the CIA register bus, granting one register access per phi2 cycle, shared between the drive CPU (strict priority) and a host-side sequencer port.
- The host port performs single reads and writes, plus a poll operation: repeated reads until a masked match or a timeout.
- Used by mount/config logic to inspect or preload CIA state without disturbing cycle-exact CPU accesses.

Parameters:
- DIV, 16, clk cycles per phi2 cycle; even, >=4.
- POLL_MAX, 255, maximum poll reads before timeout; 1..255.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- phi2_p  out  1  one-clk strobe, phi2 rising edge
- phi2_n  out  1  one-clk strobe, phi2 falling edge
- cia_cs_n  out  1  CIA chip select, active low
- cia_rw  out  1  1=read, 0=write
- cia_rs  out  4  CIA register select
- cia_din  out  8  write data to CIA
- cia_dout  in  8  CIA read data (registered by CIA on phi2_n)
- cpu_req  in  1  CPU access request, level, sampled at slot start
- cpu_rw  in  1  CPU direction
- cpu_rs  in  4  CPU register select
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  CPU read data
- cpu_done  out  1  one-clk pulse, CPU access complete
- host_req  in  1  host request, 4-phase handshake
- host_op  in  2  0=read, 1=write, 2=poll, 3=reserved (treated as read)
- host_rs  in  4  host register select
- host_wdata  in  8  host write data
- host_mask  in  8  poll mask
- host_match  in  8  poll compare value
- host_ack  out  1  one-clk pulse, host op complete
- host_rdata  out  8  last read data
- host_timeout  out  1  valid with host_ack; 1 = poll exhausted
- bus_owner  out  2  0=idle, 1=cpu, 2=host, for the current slot

Behaviour:
- Reset: phase counter = 0, phi2_p = phi2_n = 0, cia_cs_n = 1, cia_rw = 1, cia_rs = 0, cia_din = 0, cpu_rdata = 0, cpu_done = 0, host_ack = 0, host_rdata = 0, host_timeout = 0, bus_owner = 0, host FSM = IDLE, poll count = 0. Any in-flight op is dropped without an ack.
- Phase counter: counts 0..DIV-1 and wraps.
  - phi2_p = 1 when count == 0.
  - phi2_n = 1 when count == DIV/2.
- Slot: one slot per phi2 cycle. Arbitration is evaluated at count == 0.
  - cpu_req = 1: CPU owns the slot.
  - Else, if the host FSM is in ACCESS: host owns the slot.
  - Else: idle.
- Bus timing within a slot:
  - Owner's cs_n/rw/rs/din are registered and held from count 1 through count DIV-1.
  - Idle slot and count 0: cs_n = 1, rw = 1.
- Read capture: cia_dout is captured at count == DIV/2+1.
  - CPU slot: cpu_rdata is loaded and cpu_done pulses in that cycle. CPU writes also pulse cpu_done in that cycle.
  - Host slot: result is evaluated in the same cycle.
- Host FSM:
  - IDLE: host_req = 1 latches op/rs/wdata/mask/match, clears poll count, goes to ACCESS.
  - ACCESS: waits for a granted host slot; at capture, goes to EVAL.
  - EVAL (1 clk):
    - read/write: host_ack = 1, goes to DONE.
    - poll with (dout & mask) == (match & mask): host_ack = 1, host_timeout = 0, goes to DONE.
    - poll, no match: poll count +1. If the count reaches POLL_MAX: host_ack = 1, host_timeout = 1, goes to DONE. Otherwise returns to ACCESS; the next read uses a later slot, never the same slot.
  - DONE: waits for host_req = 0, then goes to IDLE. host_rdata/host_timeout hold until the next ack.
- Host input changes while not in IDLE are ignored.
- A CPU request at count == 0 always preempts the host; the host can starve indefinitely. This is by design: drive CPU timing is cycle-exact.
- cpu_req sampled at other counts is ignored. The CPU must hold cpu_req through count 0.
- Host polling of ICR (rs = 0xD) clears CIA interrupt flags. The block does not prevent this; callers must not poll ICR while the CPU is running.
- bus_owner updates at count 1 and returns to 0 at the next count 0.

Test Plan:
- Reset mid-poll (host in ACCESS, count = 5): assert reset 1 clk -> all outputs at reset values, no host_ack, FSM IDLE; phi2_p first reappears DIV clks after reset release.
- DIV = 16, cpu_req = 1, rw = 1, rs = 0x2, CIA returns 0x5A -> cs_n low for counts 1–15, cpu_rdata = 0x5A with cpu_done at count 9, bus_owner = 1.
- Host write op = 1, rs = 0x4, wdata = 0x34, cpu_req = 0 -> cia_rw = 0, cia_din = 0x34 during the next slot, host_ack at count 9; holding host_req high produces no second access.
- Host read with cpu_req = 1 for 3 slots -> host access occurs in slot 4 only, CPU done pulses in slots 1–3.
- Poll rs = 0xD, mask = 0x08, match = 0x08; dout = 0x00 for 4 reads, then 0x88 -> 5 host slots, host_ack with host_timeout = 0, host_rdata = 0x88.
- Poll with POLL_MAX = 3, never matching -> exactly 3 reads, host_ack with host_timeout = 1.
